// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, command field positions, FSM states and multiplier constants for exec_alu_unit
package exec_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU, OP_MUL, OP_PASS
    } alu_op_e;
    localparam int CMD_OP_LSB = 0;
    localparam int CMD_OP_MSB = 3;
    localparam int CMD_MEM_BIT = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL_BUSY, ST_MUL_DONE} state_e;
    localparam int MUL_ITERS = 16;
    localparam int MUL_BITS_PER_ITER = 4;
endpackage

// File: rtl/exec_alu_unit_mul.sv
// exec_mul_iter: iterative 64x64 low multiplier, radix-16 shift-add, one nibble of b per cycle
module exec_mul_iter
    import exec_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o
);
    localparam int CNT_W = $clog2(MUL_ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_ITERS - 1);
    logic [63:0] a_q, b_q, acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic busy_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q <= a_i;
            b_q <= b_i;
            acc_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_q + a_q * 64'(b_q[MUL_BITS_PER_ITER-1:0]);
            a_q <= a_q << MUL_BITS_PER_ITER;
            b_q <= b_q >> MUL_BITS_PER_ITER;
            cnt_q <= cnt_q + 1'b1;
            busy_q <= cnt_q != LAST;
        end
    end
    assign busy_o = busy_q;
    // done_o flags the cycle whose edge completes the last iteration
    assign done_o = busy_q & (cnt_q == LAST);
    assign result_o = acc_q;
endmodule

// File: rtl/exec_alu_unit.sv
// exec_alu_unit: ALU/address execute stage with registered tagged result; iterative MUL under EXEC_ALU_MUL_EN
module exec_alu_unit
    import exec_pkg::*;
#(
    parameter int ROBsize = 16,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  needToRestore_i,
    input  logic                  rsReady_i,
    input  logic [63:0]           rsVal1_i,
    input  logic [63:0]           rsVal2_i,
    input  logic [63:0]           rsVal3_i,
    input  logic [9:0]            rsCommands_i,
    input  logic [ROBsizeLog-1:0] rsTag_i,
    output logic                  stall_o,
    input  logic                  stall_i,
    output logic [ROBsizeLog-1:0] resultTag_o,
    output logic [64:0]           resultVal_o,
    output logic                  resultMemAccess_o,
    output logic [63:0]           resultStoreData_o,
    output logic [9:0]            resultCommands_o
);
    state_e state_q, state_d;
    logic valid_q, valid_d, mem_q, mem_d;
    logic [ROBsizeLog-1:0] tag_q, tag_d;
    logic [63:0] val_q, val_d, store_q, store_d;
    logic [9:0] cmd_q, cmd_d;
    logic accept, mem, is_mul, free, load_mul;
    logic [63:0] alu_res;
    alu_op_e op;
    logic [5:0] sh;
    assign op = alu_op_e'(rsCommands_i[CMD_OP_MSB:CMD_OP_LSB]);
    assign mem = rsCommands_i[CMD_MEM_BIT];
    assign sh = rsVal2_i[5:0];
    assign accept = rsReady_i & ~stall_o & ~needToRestore_i;
    assign free = ~valid_q | ~stall_i;
    assign stall_o = reset_i | (state_q != ST_IDLE) | (valid_q & stall_i) | needToRestore_i;
`ifdef EXEC_ALU_MUL_EN
    logic [63:0] pend_store_q, mul_res;
    logic [9:0] pend_cmd_q;
    logic [ROBsizeLog-1:0] pend_tag_q;
    logic mul_busy, mul_done;
    assign is_mul = (op == OP_MUL) & ~mem;
    assign load_mul = (state_q == ST_MUL_DONE) & free;
    exec_mul_iter u_mul (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (accept & is_mul),
        .abort_i  (needToRestore_i),
        .a_i      (rsVal1_i),
        .b_i      (rsVal2_i),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .result_o (mul_res)
    );
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_store_q <= '0;
            pend_cmd_q <= '0;
            pend_tag_q <= '0;
        end else if (accept & is_mul) begin
            pend_store_q <= rsVal3_i;
            pend_cmd_q <= rsCommands_i;
            pend_tag_q <= rsTag_i;
        end
    end
`else
    assign is_mul = 1'b0;
    assign load_mul = 1'b0;
`endif
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rsVal1_i + rsVal2_i;
            OP_SUB:  alu_res = rsVal1_i - rsVal2_i;
            OP_AND:  alu_res = rsVal1_i & rsVal2_i;
            OP_OR:   alu_res = rsVal1_i | rsVal2_i;
            OP_XOR:  alu_res = rsVal1_i ^ rsVal2_i;
            OP_SLL:  alu_res = rsVal1_i << sh;
            OP_SRL:  alu_res = rsVal1_i >> sh;
            OP_SRA:  alu_res = $signed(rsVal1_i) >>> sh;
            OP_SLT:  alu_res = {63'd0, $signed(rsVal1_i) < $signed(rsVal2_i)};
            OP_SLTU: alu_res = {63'd0, rsVal1_i < rsVal2_i};
            OP_PASS: alu_res = rsVal2_i;
            default: alu_res = '0;
        endcase
        if (mem) alu_res = rsVal1_i + rsVal2_i;
    end
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        tag_d = tag_q;
        val_d = val_q;
        mem_d = mem_q;
        store_d = store_q;
        cmd_d = cmd_q;
`ifdef EXEC_ALU_MUL_EN
        if (accept & is_mul) state_d = ST_MUL_BUSY;
        if ((state_q == ST_MUL_BUSY) & mul_done & mul_busy) state_d = ST_MUL_DONE;
`endif
        if (needToRestore_i) begin
            state_d = ST_IDLE;
            {valid_d, tag_d, val_d, mem_d, store_d, cmd_d} = '0;
        end else if (accept & ~is_mul) begin
            valid_d = 1'b1;
            tag_d = rsTag_i;
            val_d = alu_res;
            mem_d = mem;
            store_d = rsVal3_i;
            cmd_d = rsCommands_i;
`ifdef EXEC_ALU_MUL_EN
        end else if (load_mul) begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
            tag_d = pend_tag_q;
            val_d = mul_res;
            mem_d = 1'b0;
            store_d = pend_store_q;
            cmd_d = pend_cmd_q;
`endif
        end else if (free) begin
            {valid_d, tag_d, val_d, mem_d, store_d, cmd_d} = '0;
        end
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            tag_q <= '0;
            val_q <= '0;
            mem_q <= 1'b0;
            store_q <= '0;
            cmd_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q <= tag_d;
            val_q <= val_d;
            mem_q <= mem_d;
            store_q <= store_d;
            cmd_q <= cmd_d;
        end
    end
    assign resultTag_o = tag_q;
    assign resultVal_o = {valid_q, val_q};
    assign resultMemAccess_o = mem_q;
    assign resultStoreData_o = store_q;
    assign resultCommands_o = cmd_q;
    logic unused_load;
    assign unused_load = load_mul;
endmodule

// File: tb/tb_exec_alu_unit.sv
// tb_exec_alu_unit: directed self-checking bench for exec_alu_unit (MUL expectations follow EXEC_ALU_MUL_EN)
module tb_exec_alu_unit;
    import exec_pkg::*;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic needToRestore_i = 1'b0, rsReady_i = 1'b0, stall_i = 1'b0;
    logic [63:0] rsVal1_i = '0, rsVal2_i = '0, rsVal3_i = '0;
    logic [9:0] rsCommands_i = '0;
    logic [4:0] rsTag_i = '0;
    logic stall_o, resultMemAccess_o;
    logic [4:0] resultTag_o;
    logic [64:0] resultVal_o;
    logic [63:0] resultStoreData_o;
    logic [9:0] resultCommands_o;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    exec_alu_unit dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .needToRestore_i   (needToRestore_i),
        .rsReady_i         (rsReady_i),
        .rsVal1_i          (rsVal1_i),
        .rsVal2_i          (rsVal2_i),
        .rsVal3_i          (rsVal3_i),
        .rsCommands_i      (rsCommands_i),
        .rsTag_i           (rsTag_i),
        .stall_o           (stall_o),
        .stall_i           (stall_i),
        .resultTag_o       (resultTag_o),
        .resultVal_o       (resultVal_o),
        .resultMemAccess_o (resultMemAccess_o),
        .resultStoreData_o (resultStoreData_o),
        .resultCommands_o  (resultCommands_o)
    );
    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [9:0] cmd, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [4:0] tag);
        rsReady_i = 1'b1;
        rsCommands_i = cmd;
        rsVal1_i = a;
        rsVal2_i = b;
        rsVal3_i = c;
        rsTag_i = tag;
    endtask
    task automatic issue(input logic [9:0] cmd, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag);
        drive(cmd, a, b, 64'd0, tag);
        tick();
        rsReady_i = 1'b0;
    endtask
    initial begin
        #3;
        chk("reset_stall", stall_o, 1);
        chk("reset_val", resultVal_o, 0);
        chk("reset_tag", resultTag_o, 0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("post_reset_stall", stall_o, 0);
        tick();
        issue(10'd0, 64'd5, 64'd7, 5'd3);
        chk("add_val", resultVal_o, {1'b1, 64'd12});
        chk("add_tag", resultTag_o, 3);
        chk("add_stall", stall_o, 0);
        chk("add_mem", resultMemAccess_o, 0);
        issue(10'd7, 64'h8000_0000_0000_0000, 64'd4, 5'd4);
        chk("sra", resultVal_o, {1'b1, 64'hF800_0000_0000_0000});
        issue(10'd9, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5);
        chk("sltu", resultVal_o, {1'b1, 64'd1});
        issue(10'd8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6);
        chk("slt_false", resultVal_o, {1'b1, 64'd0});
        issue(10'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6);
        chk("slt_true", resultVal_o, {1'b1, 64'd1});
        issue(10'd1, 64'd5, 64'd7, 5'd7);
        chk("sub_wrap", resultVal_o, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        issue(10'd5, 64'd1, 64'd63, 5'd7);
        chk("sll63", resultVal_o, {1'b1, 64'h8000_0000_0000_0000});
        issue(10'd5, 64'd1, 64'd65, 5'd7);
        chk("sll_mask6", resultVal_o, {1'b1, 64'd2});
        issue(10'd6, 64'h8000_0000_0000_0000, 64'd63, 5'd7);
        chk("srl63", resultVal_o, {1'b1, 64'd1});
        issue(10'd4, 64'hF0F0, 64'hFF00, 5'd7);
        chk("xor", resultVal_o, {1'b1, 64'h0FF0});
        issue(10'd2, 64'hF0F0, 64'hFF00, 5'd7);
        chk("and", resultVal_o, {1'b1, 64'hF000});
        issue(10'd3, 64'hF0F0, 64'hFF00, 5'd7);
        chk("or", resultVal_o, {1'b1, 64'hFFF0});
        issue(10'd11, 64'd9, 64'h1234, 5'd7);
        chk("pass", resultVal_o, {1'b1, 64'h1234});
        issue(10'd13, 64'd9, 64'h1234, 5'd7);
        chk("op13_zero", resultVal_o, {1'b1, 64'd0});
        drive(10'h3F1, 64'h1000, 64'h20, 64'hAB, 5'd2);
        tick();
        rsReady_i = 1'b0;
        chk("mem_addr", resultVal_o, {1'b1, 64'h1020});
        chk("mem_flag", resultMemAccess_o, 1);
        chk("mem_store", resultStoreData_o, 64'hAB);
        chk("mem_cmd", resultCommands_o, 10'h3F1);
        drive(10'd0, 64'd1, 64'd2, 64'd0, 5'd10);
        tick();
        chk("b2b_first", {resultTag_o, resultVal_o}, {5'd10, 1'b1, 64'd3});
        drive(10'd0, 64'd4, 64'd4, 64'd0, 5'd11);
        tick();
        rsReady_i = 1'b0;
        chk("b2b_second", {resultTag_o, resultVal_o}, {5'd11, 1'b1, 64'd8});
        tick();
        chk("drain_val", resultVal_o, 0);
        chk("drain_tag", resultTag_o, 0);
        issue(10'd10, 64'h1_0000_0001, 64'd3, 5'd12);
`ifdef EXEC_ALU_MUL_EN
        chk("mul_stall_0", stall_o, 1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("mul_busy_stall", stall_o, 1);
            chk("mul_busy_invalid", resultVal_o[64], 0);
        end
        tick();
        chk("mul_val", resultVal_o, {1'b1, 64'h3_0000_0003});
        chk("mul_tag", resultTag_o, 12);
        chk("mul_done_stall", stall_o, 0);
`else
        chk("mul_off_val", resultVal_o, {1'b1, 64'd0});
        chk("mul_off_tag", resultTag_o, 12);
        chk("mul_off_stall", stall_o, 0);
`endif
        issue(10'd0, 64'd1, 64'd1, 5'd6);
        stall_i = 1'b1;
        drive(10'd0, 64'd10, 64'd20, 64'd0, 5'd7);
        #1;
        chk("stall_comb", stall_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {resultTag_o, resultVal_o}, {5'd6, 1'b1, 64'd2});
            chk("stall_o_hold", stall_o, 1);
        end
        stall_i = 1'b0;
        #1;
        chk("stall_release", stall_o, 0);
        tick();
        rsReady_i = 1'b0;
        chk("stall_next", {resultTag_o, resultVal_o}, {5'd7, 1'b1, 64'd30});
        issue(10'd0, 64'd2, 64'd2, 5'd8);
        needToRestore_i = 1'b1;
        drive(10'd0, 64'd3, 64'd3, 64'd0, 5'd13);
        #1;
        chk("flush_stall", stall_o, 1);
        tick();
        needToRestore_i = 1'b0;
        rsReady_i = 1'b0;
        chk("flush_val", resultVal_o, 0);
        chk("flush_tag", resultTag_o, 0);
`ifdef EXEC_ALU_MUL_EN
        issue(10'd10, 64'd2, 64'd3, 5'd14);
        for (int i = 0; i < 4; i++) tick();
        needToRestore_i = 1'b1;
        tick();
        needToRestore_i = 1'b0;
        chk("mul_flush_val", resultVal_o[64], 0);
        chk("mul_flush_idle", stall_o, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mul_flush_notag", resultTag_o, 0);
        end
`endif
        issue(10'd0, 64'd100, 64'd23, 5'd9);
        chk("post_flush_add", {resultTag_o, resultVal_o}, {5'd9, 1'b1, 64'd123});
        issue(10'd0, 64'd1, 64'd1, 5'd15);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_reset_val", resultVal_o, 0);
        chk("async_reset_stall", stall_o, 1);
        tick();
        reset_i = 1'b0;
        #1;
        chk("reset_release_stall", stall_o, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
